// File: rtl/arb_pkg.sv
// Shared types and constants for the I/D-cache memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int unsigned BLOCK_WORDS = 8;
  localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;

endpackage

// File: rtl/fill_counter.sv
// Issue and return word counters for one block fill, cleared while the arbiter is idle.
module fill_counter
  import arb_pkg::*;
#(
  parameter int unsigned Words = BLOCK_WORDS
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       issue_i,
  input  logic       ret_i,
  output logic [2:0] issue_cnt_o,
  output logic [2:0] ret_cnt_o,
  output logic       issue_done_o,
  output logic       ret_last_o
);

  localparam logic [2:0] LastIdx = 3'(Words - 1);

  logic [2:0] issue_cnt_q, ret_cnt_q;
  logic       issue_done_q;
  logic       issue_last;

  assign issue_last = (issue_cnt_q == LastIdx);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      issue_cnt_q  <= 3'd0;
      ret_cnt_q    <= 3'd0;
      issue_done_q <= 1'b0;
    end else begin
      if (issue_i) begin
        issue_cnt_q <= issue_cnt_q + 3'd1;
        // The counter wraps after the last word; the flag stops further issues.
        if (issue_last) issue_done_q <= 1'b1;
      end
      if (ret_i) ret_cnt_q <= ret_cnt_q + 3'd1;
    end
  end

  assign issue_cnt_o  = issue_cnt_q;
  assign ret_cnt_o    = ret_cnt_q;
  assign issue_done_o = issue_done_q;
  assign ret_last_o   = (ret_cnt_q == LastIdx);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writes onto one main-memory port.
// Build option: define ARB_RR_EN for round-robin tie-break (default is fixed D priority).
module mem_arbiter #(
  parameter int unsigned MEM_LAT     = 4,
  parameter int unsigned BLOCK_WORDS = arb_pkg::BLOCK_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_grant,
  output logic        i_fill_valid,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_grant,
  output logic        d_fill_valid,
  output logic        d_done,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_en,
  output logic        mem_wr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_data_valid,
  output logic        busy
);
  import arb_pkg::*;

  state_e      state_q, state_d;
  owner_e      owner_q;
  logic [15:0] addr_q, wdata_q;
  logic        pick_d, arb_go, fill_done;
  logic        cnt_clear, cnt_issue, cnt_ret;
  logic [2:0]  issue_cnt, ret_cnt;
  logic        issue_done, ret_last;

  // Latency is absorbed by counting returns, so the value never reaches the logic.
  logic unused_lat;
  assign unused_lat = ^32'(MEM_LAT);

`ifdef ARB_RR_EN
  logic last_d_q;
  assign pick_d = d_req && (!i_req || !last_d_q);
  always_ff @(posedge clk) begin
    if (rst)         last_d_q <= 1'b1;
    else if (arb_go) last_d_q <= pick_d;
  end
`else
  assign pick_d = d_req;
`endif

  assign arb_go    = (state_q == IDLE) && (i_req || d_req);
  assign fill_done = (state_q == FILL) && mem_data_valid && ret_last;
  assign cnt_clear = (state_q == IDLE);
  assign cnt_issue = (state_q == FILL) && !issue_done;
  assign cnt_ret   = (state_q == FILL) && mem_data_valid;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_go) state_d = (pick_d && d_wr) ? WRITE : FILL;
      FILL:    if (fill_done) state_d = IDLE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= OWN_I;
      addr_q  <= 16'h0;
      wdata_q <= 16'h0;
    end else if (arb_go) begin
      owner_q <= pick_d ? OWN_D : OWN_I;
      if (pick_d && d_wr) begin
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
      end else begin
        addr_q  <= (pick_d ? d_addr : i_addr) & BLOCK_MASK;
        wdata_q <= 16'h0;
      end
    end
  end

  fill_counter #(
    .Words(BLOCK_WORDS)
  ) u_fill_counter (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (cnt_clear),
    .issue_i     (cnt_issue),
    .ret_i       (cnt_ret),
    .issue_cnt_o (issue_cnt),
    .ret_cnt_o   (ret_cnt),
    .issue_done_o(issue_done),
    .ret_last_o  (ret_last)
  );

  // Outputs are forced low during reset, even in the cycle the state is still active.
  always_comb begin
    i_grant      = 1'b0;
    i_fill_valid = 1'b0;
    i_done       = 1'b0;
    d_grant      = 1'b0;
    d_fill_valid = 1'b0;
    d_done       = 1'b0;
    fill_data    = 16'h0;
    fill_word    = 3'd0;
    mem_addr     = 16'h0;
    mem_wdata    = 16'h0;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    busy         = 1'b0;
    if (!rst) begin
      busy = (state_q != IDLE);
      unique case (state_q)
        FILL: begin
          i_grant = (owner_q == OWN_I);
          d_grant = (owner_q == OWN_D);
          if (!issue_done) begin
            mem_en   = 1'b1;
            mem_addr = addr_q + {12'h0, issue_cnt, 1'b0};
          end
          if (mem_data_valid) begin
            i_fill_valid = (owner_q == OWN_I);
            d_fill_valid = (owner_q == OWN_D);
            fill_data    = mem_rdata;
            fill_word    = ret_cnt;
            i_done       = fill_done && (owner_q == OWN_I);
            d_done       = fill_done && (owner_q == OWN_D);
          end
        end
        WRITE: begin
          d_grant   = 1'b1;
          mem_en    = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
          d_done    = 1'b1;
        end
        IDLE:    ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level timeline model predicts every
// grant window, memory issue and fill return; a negedge monitor checks the DUT cycle by cycle.
module tb_mem_arbiter;

  localparam int MEM_LAT = 4;

  logic        clk, rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, i_fill_valid, i_done, d_grant, d_fill_valid, d_done;
  logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  fill_word;
  logic        mem_en, mem_wr, mem_data_valid, busy;

  mem_arbiter #(
    .MEM_LAT    (MEM_LAT),
    .BLOCK_WORDS(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_req         (i_req),
    .i_addr        (i_addr),
    .i_grant       (i_grant),
    .i_fill_valid  (i_fill_valid),
    .i_done        (i_done),
    .d_req         (d_req),
    .d_wr          (d_wr),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_grant       (d_grant),
    .d_fill_valid  (d_fill_valid),
    .d_done        (d_done),
    .fill_data     (fill_data),
    .fill_word     (fill_word),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_en        (mem_en),
    .mem_wr        (mem_wr),
    .mem_rdata     (mem_rdata),
    .mem_data_valid(mem_data_valid),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {int at; logic [15:0] addr; logic wr; logic [15:0] wdata;} iss_t;
  typedef struct {int at; logic d_side; logic [2:0] word; logic [15:0] data;} fil_t;
  typedef struct {int due; logic [15:0] data;} pend_t;

  iss_t  exp_iss[$];
  fil_t  exp_fil[$];
  pend_t pend[$];
  logic  done_log[$];

  // Reference timeline: one owner at a time, grant window [m_g, m_done].
  bit m_busy = 1'b0, m_d = 1'b0, m_wr = 1'b0, last_d = 1'b1;
  int m_g = 0, m_done = 0;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0] ^ 8'h5A, a[15:8]} + 16'h1357;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic own;
    iss_t e;
    fil_t f;
    own = m_busy && cyc >= m_g && cyc <= m_done;
    check("grant_done_busy", {59'd0, i_grant, i_done, d_grant, d_done, busy},
          {59'd0, own && !m_d, own && !m_d && cyc == m_done, own && m_d,
           own && m_d && cyc == m_done, own});
    if (exp_iss.size() > 0 && exp_iss[0].at == cyc) begin
      e = exp_iss.pop_front();
      check("mem_issue", {mem_en, mem_wr, mem_addr, e.wr ? mem_wdata : 16'h0},
            {1'b1, e.wr, e.addr, e.wdata});
    end else begin
      check("mem_quiet", {mem_en, own ? 33'h0 : {mem_wr, mem_addr, mem_wdata}}, 64'd0);
    end
    if (exp_fil.size() > 0 && exp_fil[0].at == cyc) begin
      f = exp_fil.pop_front();
      check("fill_return", {i_fill_valid, d_fill_valid, fill_word, fill_data},
            {!f.d_side, f.d_side, f.word, f.data});
    end else begin
      check("fill_quiet", {i_fill_valid, d_fill_valid}, 64'd0);
    end
  endtask

  task automatic model_step();
    logic        pick_d;
    logic [15:0] base;
    if ((m_busy && cyc <= m_done) || !(i_req || d_req)) return;
    pick_d = d_req;
`ifdef ARB_RR_EN
    if (i_req && d_req) pick_d = !last_d;
    last_d = pick_d;
`endif
    m_busy = 1'b1;
    m_d    = pick_d;
    m_wr   = pick_d && d_wr;
    m_g    = cyc + 1;
    if (m_wr) begin
      m_done = m_g;
      exp_iss.push_back('{at: m_g, addr: d_addr, wr: 1'b1, wdata: d_wdata});
    end else begin
      base   = (pick_d ? d_addr : i_addr) & 16'hFFF0;
      m_done = m_g + MEM_LAT + 7;
      for (int k = 0; k < 8; k++) begin
        exp_iss.push_back('{at: m_g + k, addr: base + 16'(2 * k), wr: 1'b0, wdata: 16'h0});
        exp_fil.push_back('{at: m_g + MEM_LAT + k, d_side: pick_d, word: 3'(k),
                            data: mem_fn(base + 16'(2 * k))});
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("reset_zero", {4'd0, i_grant, i_fill_valid, i_done, d_grant, d_fill_valid, d_done,
                           busy, mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word},
            64'd0);
      exp_iss.delete();
      exp_fil.delete();
      m_busy = 1'b0;
      last_d = 1'b1;
    end else begin
      monitor();
      if (i_done) done_log.push_back(1'b0);
      if (d_done) done_log.push_back(1'b1);
      model_step();
    end
    if (mem_en && !mem_wr) pend.push_back('{due: cyc + MEM_LAT, data: mem_fn(mem_addr)});
  end

  // Fixed-latency memory; also drops junk valids whenever no fill can be in progress.
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mem_data_valid = 1'b1;
      mem_rdata      = pend[0].data;
      void'(pend.pop_front());
    end else begin
      mem_rdata      = 16'($urandom);
      mem_data_valid = (!(m_busy && cyc >= m_g && cyc <= m_done) || m_wr) &&
                       ($urandom_range(0, 7) == 0);
    end
  end

  task automatic wait_done(input bit d_side, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      @(negedge clk);
      ok = d_side ? d_done : i_done;
    end
    check("done_seen", {63'd0, ok}, 64'd1);
  endtask

  task automatic i_seq(input int n, input bit rnd, input logic [15:0] a0);
    bit ok;
    int gap;
    for (int t = 0; t < n; t++) begin
      i_addr = rnd ? 16'($urandom) : a0 + 16'(t * 256);
      i_req  = 1'b1;
      wait_done(1'b0, ok);
      tick();
      gap = rnd ? int'($urandom_range(0, 3)) : 0;
      if (gap > 0 || t == n - 1) begin
        i_req = 1'b0;
        repeat (gap) tick();
      end
    end
  endtask

  task automatic d_seq(input int n, input bit rnd, input logic wr, input logic [15:0] a0,
                       input logic [15:0] wd);
    bit ok;
    int gap;
    for (int t = 0; t < n; t++) begin
      d_wr    = rnd ? 1'($urandom_range(0, 1)) : wr;
      d_addr  = rnd ? 16'($urandom) : a0 + 16'(t * 256);
      d_wdata = rnd ? 16'($urandom) : wd;
      d_req   = 1'b1;
      wait_done(1'b1, ok);
      tick();
      gap = rnd ? int'($urandom_range(0, 3)) : 0;
      if (gap > 0 || t == n - 1) begin
        d_req = 1'b0;
        repeat (gap) tick();
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit ok;
    int cnt;
    logic [1:0] exp_order;
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    mem_rdata = 16'h0; mem_data_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Tie from reset: I fills twice back to back, D fills once.
    fork
      i_seq(2, 1'b0, 16'h0100);
      d_seq(1, 1'b0, 1'b0, 16'h0200, 16'h0);
    join
`ifdef ARB_RR_EN
    exp_order = 2'b01;  // I first, then D wins the following tie
`else
    exp_order = 2'b10;  // D first, then I in the idle cycle after d_done
`endif
    check("tie_order_count", 64'(done_log.size() >= 2), 64'd1);
    if (done_log.size() >= 2) check("tie_order", {62'd0, done_log[0], done_log[1]}, 64'(exp_order));

    i_seq(1, 1'b0, 16'h0036);
    repeat (2) tick();
    d_seq(1, 1'b0, 1'b1, 16'h1234, 16'hBEEF);
    repeat (2) tick();

    // Owner drops its request mid-fill; the fill still completes.
    i_addr = 16'h0ABC;
    i_req  = 1'b1;
    repeat (3) tick();
    i_req = 1'b0;
    wait_done(1'b0, ok);
    tick();

    // Reset after the third return, then a fresh fill once stale returns have drained.
    i_addr = 16'h2046;
    i_req  = 1'b1;
    cnt    = 0;
    for (int n = 0; n < 100 && cnt < 3; n++) begin
      @(negedge clk);
      if (i_fill_valid) cnt++;
    end
    check("third_return", 64'(cnt), 64'd3);
    tick();
    rst   = 1'b1;
    i_req = 1'b0;
    tick();
    rst = 1'b0;
    repeat (12) tick();
    i_seq(1, 1'b0, 16'h3000);

    fork
      i_seq(25, 1'b1, 16'h0);
      d_seq(25, 1'b1, 1'b0, 16'h0, 16'h0);
    join
    repeat (20) tick();
    check("queues_drained", 64'(exp_iss.size() + exp_fil.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 4: main-memory read latency in cycles, from mem_en to mem_data_valid.
REQ-002 Parameter BLOCK_WORDS, default 8: 16-bit words per cache block (16-byte block).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 i_req  in  1  I-cache miss request; held high until i_done.
REQ-006 i_addr  in  16  I-cache miss byte address.
REQ-007 i_grant / i_fill_valid / i_done  out  1 each  I-side grant, fill word valid, one-cycle completion pulse.
REQ-008 d_req  in  1  D-cache request (miss or write); held high until d_done.
REQ-009 d_wr  in  1  D-cache request type, 1 = single-word write, 0 = block fill.
REQ-010 d_addr / d_wdata  in  16 each  D-cache byte address and write data.
REQ-011 d_grant / d_fill_valid / d_done  out  1 each  D-side equivalents of the I-side outputs.
REQ-012 fill_data  out  16  returned word, shared by both sides.
REQ-013 fill_word  out  3  word index within the block for fill_data.
REQ-014 mem_addr / mem_wdata  out  16 each  main-memory address and write data.
REQ-015 mem_en / mem_wr  out  1 each  memory enable and write strobe.
REQ-016 mem_rdata  in  16  memory read data.
REQ-017 mem_data_valid  in  1  memory read data valid.
REQ-018 busy  out  1  high whenever the state is not IDLE.

Function
REQ-019 FSM states: IDLE, FILL, WRITE.
REQ-020 IDLE, both requests low: stay in IDLE; all memory outputs are 0.
REQ-021 IDLE, a request present: on the next edge, register the winner, assert its grant and enter FILL or WRITE; grant stays high through the cycle of its done pulse.
REQ-022 Arbitration when both requests are high: D wins, subject to REQ-034.
REQ-023 Fill block base: addr & 16'hFFF0, captured at grant.
REQ-024 Fill issue: for k = 0..7 on the 8 consecutive cycles starting at the grant cycle, mem_en=1, mem_wr=0, mem_addr = base + 2k.
REQ-025 Fill return: each mem_data_valid during FILL asserts the owner's fill_valid in the same cycle; fill_data = mem_rdata (combinational); fill_word = return count.
REQ-026 Fill completion: the 8th valid also pulses the owner's done; FSM returns to IDLE on the next edge.
REQ-027 Fill latency: done at grant cycle + MEM_LAT + 7.
REQ-028 Write: in the grant cycle, mem_en=1, mem_wr=1, mem_addr = d_addr, mem_wdata = d_wdata, and d_done pulses; return to IDLE on the next edge.
REQ-029 A new arbitration occurs in the IDLE cycle after every done; no request is granted in a done cycle.
REQ-030 Ignored inputs: mem_data_valid outside FILL, and deassertion of the owner's request mid-operation. The operation always completes.
REQ-031 The non-owner's fill_valid, done and grant stay 0 for the whole operation.

Reset
REQ-032 While rst is high: state = IDLE, counters = 0, and every output (grants, valids, dones, busy, mem_*, fill_data, fill_word) = 0.
REQ-033 Reset asserted mid-FILL or mid-WRITE aborts the operation with no done pulse; memory returns still in flight after reset are ignored per REQ-030.

Configuration
REQ-034 Macro ARB_RR_EN:
- Defined: round-robin tie-break. A tie goes to the side not granted last; the last-granted flag resets to D, so I wins the first tie.
- Undefined: fixed D priority per REQ-022.

Structure
REQ-035 Shared package arb_pkg holds: the state enum (IDLE, FILL, WRITE), BLOCK_WORDS, BLOCK_MASK = 16'hFFF0, and the owner encoding (OWN_I, OWN_D).
REQ-036 One sub-module, fill_counter: holds the 3-bit issue and return counters with terminal-count flags, and is instantiated once.

Verification
REQ-037 Lone I fill, i_addr=16'h0036, MEM_LAT=4 -> mem_addr 0x0030..0x003E on 8 consecutive cycles; i_fill_valid with fill_word 0..7; i_done at grant+11.
REQ-038 i_req and d_req (fill) both high in IDLE, macro undefined -> D served first; I granted in the IDLE cycle after d_done.
REQ-039 Same stimulus with ARB_RR_EN defined, first tie after reset -> I served first; next tie -> D served first.
REQ-040 D write, d_addr=16'h1234, d_wdata=16'hBEEF -> one cycle of mem_en=1, mem_wr=1 with that address and data; d_done pulses in that cycle; FSM back to IDLE next cycle.
REQ-041 rst pulsed after the 3rd return of a fill -> all outputs 0 and no done pulse; stale valids ignored; a new i_req is fully serviced.
